// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing controller for the 8x8 sequential multiplier.
// Steps a 4x4 multiplier datapath through four nibble products.
//
// Ports:
//   clk        : clock
//   aclr_n     : asynchronous active-low reset
//   start      : multiply request
//   input_sel  : nibble select (00 lo*lo, 01 hi*lo, 10 lo*hi, 11 hi*hi)
//   shift_sel  : product shift (00 <<0, 01 <<4, 10 <<8)
//   clk_ena    : accumulator load enable
//   sclr_n     : accumulator synchronous clear, active-low
//   busy       : operation in progress (LSB/MID/MSB)
//   done_flag  : product valid in the accumulator
//   err        : launch seen while busy
//   state_out  : state code for display/debug
//   step_count : internal step counter
//   ops_count  : saturating count of completed operations
//                (only when MULT_SEQ_OPS_CNT_EN is defined)
//
// Parameters:
//   START_EDGE : 1 = launch on rising edge of start, 0 = on start level
//   OPS_W      : width of ops_count
module mult_seq_ctrl #(
    parameter bit START_EDGE = 1'b1,
    parameter int OPS_W      = 16
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             start,
    output logic [1:0]       input_sel,
    output logic [1:0]       shift_sel,
    output logic             clk_ena,
    output logic             sclr_n,
    output logic             busy,
    output logic             done_flag,
    output logic             err,
    output logic [2:0]       state_out,
    output logic [1:0]       step_count
`ifdef MULT_SEQ_OPS_CNT_EN
    ,
    output logic [OPS_W-1:0] ops_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LSB  = 3'b001,
        S_MID  = 3'b010,
        S_MSB  = 3'b011,
        S_DONE = 3'b100,
        S_ERR  = 3'b101
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_step;
    logic [1:0] w_step_nxt;
    logic       r_start_d;
    logic       w_launch;

    assign w_launch = START_EDGE ? (start & ~r_start_d) : start;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state   <= S_IDLE;
            r_step    <= 2'd0;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_start_d <= start;
        end
    end

    // A launch while busy overrides the normal step transition.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = 2'd0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_launch ? S_LSB : S_IDLE;
            end
            S_LSB: begin
                if (w_launch) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_MID;
                    w_step_nxt  = 2'd1;
                end
            end
            S_MID: begin
                if (w_launch) begin
                    w_state_nxt = S_ERR;
                end else if (r_step == 2'd1) begin
                    w_state_nxt = S_MID;
                    w_step_nxt  = 2'd2;
                end else begin
                    w_state_nxt = S_MSB;
                    w_step_nxt  = 2'd3;
                end
            end
            S_MSB: begin
                w_state_nxt = w_launch ? S_ERR : S_DONE;
            end
            S_DONE: begin
                w_state_nxt = start ? S_DONE : S_IDLE;
            end
            S_ERR: begin
                w_state_nxt = start ? S_ERR : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore decode of state/step; only the IDLE clear/enable pair
    // follows the launch combinationally so the accumulator clears
    // on the launch edge itself.
    always_comb begin
        input_sel = 2'b00;
        shift_sel = 2'b00;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        busy      = 1'b0;
        done_flag = 1'b0;
        err       = 1'b0;
        state_out = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                end
            end
            S_LSB: begin
                clk_ena   = 1'b1;
                busy      = 1'b1;
                state_out = 3'b001;
            end
            S_MID: begin
                input_sel = (r_step == 2'd1) ? 2'b01 : 2'b10;
                shift_sel = 2'b01;
                clk_ena   = 1'b1;
                busy      = 1'b1;
                state_out = 3'b010;
            end
            S_MSB: begin
                input_sel = 2'b11;
                shift_sel = 2'b10;
                clk_ena   = 1'b1;
                busy      = 1'b1;
                state_out = 3'b011;
            end
            S_DONE: begin
                done_flag = 1'b1;
                state_out = 3'b100;
            end
            S_ERR: begin
                err       = 1'b1;
                state_out = 3'b101;
            end
            default: begin
                state_out = 3'b000;
            end
        endcase
    end

    assign step_count = r_step;

`ifdef MULT_SEQ_OPS_CNT_EN
    logic [OPS_W-1:0] r_ops;
    logic             w_ops_inc;

    // Counts only the MSB->DONE step; an ERR exit from MSB is excluded.
    assign w_ops_inc = (r_state == S_MSB) && !w_launch && (r_ops != '1);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_ops <= '0;
        end else if (w_ops_inc) begin
            r_ops <= r_ops + OPS_W'(1);
        end
    end

    assign ops_count = r_ops;
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: scoreboard bench for mult_seq_ctrl with a
// behavioural 4x4 datapath/accumulator attached.
module tb_mult_seq_ctrl;

    localparam int TB_OPS_W = 2;

    // {state,step,isel,ssel,ena,sclr_n,busy,done,err}
    localparam logic [13:0] E_IDLE   = 14'b000_00_00_00_0_1_0_0_0;
    localparam logic [13:0] E_IDLE_L = 14'b000_00_00_00_1_0_0_0_0;
    localparam logic [13:0] E_LSB    = 14'b001_00_00_00_1_1_1_0_0;
    localparam logic [13:0] E_MID1   = 14'b010_01_01_01_1_1_1_0_0;
    localparam logic [13:0] E_MID2   = 14'b010_10_10_01_1_1_1_0_0;
    localparam logic [13:0] E_MSB    = 14'b011_11_11_10_1_1_1_0_0;
    localparam logic [13:0] E_DONE   = 14'b100_00_00_00_0_1_0_1_0;
    localparam logic [13:0] E_ERR    = 14'b101_00_00_00_0_1_0_0_1;

    typedef struct {
        logic [13:0] v;
        bit          co;
        logic [15:0] o;
        bit          ca;
        logic [15:0] ac;
        string       tg;
    } exp_t;

    logic       clk;
    logic       aclr_n;
    logic       start;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       clk_ena;
    logic       sclr_n;
    logic       busy;
    logic       done_flag;
    logic       err;
    logic [2:0] state_out;
    logic [1:0] step_count;
`ifdef MULT_SEQ_OPS_CNT_EN
    logic [TB_OPS_W-1:0] ops_count;
`endif

    exp_t q[$];
    int   n_chk;
    int   n_err;

    mult_seq_ctrl #(
        .START_EDGE(1'b1),
        .OPS_W     (TB_OPS_W)
    ) dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .start     (start),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .clk_ena   (clk_ena),
        .sclr_n    (sclr_n),
        .busy      (busy),
        .done_flag (done_flag),
        .err       (err),
        .state_out (state_out),
        .step_count(step_count)
`ifdef MULT_SEQ_OPS_CNT_EN
        ,
        .ops_count (ops_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath model: 4x4 nibble multiplier, shifter, accumulator.
    logic [7:0]  a_op;
    logic [7:0]  b_op;
    logic [3:0]  na;
    logic [3:0]  nb;
    logic [7:0]  prod;
    logic [15:0] sh;
    logic [15:0] acc;

    always_comb begin
        na   = input_sel[0] ? a_op[7:4] : a_op[3:0];
        nb   = input_sel[1] ? b_op[7:4] : b_op[3:0];
        prod = {4'b0, na} * {4'b0, nb};
        case (shift_sel)
            2'b00:   sh = {8'b0, prod};
            2'b01:   sh = {4'b0, prod, 4'b0};
            2'b10:   sh = {prod, 8'b0};
            default: sh = 16'h0;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)
            acc <= 16'h0;
        else if (!sclr_n)
            acc <= 16'h0;
        else if (clk_ena)
            acc <= acc + sh;
    end

    // Monitor: one expected entry per sampled cycle.
    initial begin
        exp_t        e;
        logic [13:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {state_out, step_count, input_sel, shift_sel,
                       clk_ena, sclr_n, busy, done_flag, err};
                n_chk++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL %s outputs: got %b want %b",
                             e.tg, act, e.v);
                end
                if (e.ca) begin
                    n_chk++;
                    if (acc !== e.ac) begin
                        n_err++;
                        $display("FAIL %s acc: got %h want %h",
                                 e.tg, acc, e.ac);
                    end
                end
`ifdef MULT_SEQ_OPS_CNT_EN
                if (e.co) begin
                    n_chk++;
                    if (ops_count !== e.o[TB_OPS_W-1:0]) begin
                        n_err++;
                        $display("FAIL %s ops_count: got %0d want %0d",
                                 e.tg, ops_count, e.o);
                    end
                end
`endif
            end
        end
    end

    task automatic push(input logic [13:0] v, input bit co,
                        input logic [15:0] o, input bit ca,
                        input logic [15:0] ac, input string tg);
        exp_t e;
        e.v  = v;
        e.co = co;
        e.o  = o;
        e.ca = ca;
        e.ac = ac;
        e.tg = tg;
        q.push_back(e);
    endtask

    task automatic cycx(input logic s, input logic [13:0] v,
                        input bit co, input logic [15:0] o,
                        input bit ca, input logic [15:0] ac,
                        input string tg);
        @(posedge clk);
        #1;
        start = s;
        push(v, co, o, ca, ac, tg);
    endtask

    task automatic cyc(input logic s, input logic [13:0] v,
                       input string tg);
        cycx(s, v, 1'b0, 16'h0, 1'b0, 16'h0, tg);
    endtask

    // Reset asserted mid-cycle; outputs checked before any edge.
    task automatic rst_mid(input string tg);
        @(posedge clk);
        #1;
        start = 1'b0;
        #2;
        aclr_n = 1'b0;
        push(E_IDLE, 1'b1, 16'h0, 1'b1, 16'h0, tg);
        @(negedge clk);
        #1;
        aclr_n = 1'b1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p, input bit co,
                          input logic [15:0] ops, input string tg);
        a_op = a;
        b_op = b;
        cyc(1'b1, E_IDLE_L, tg);
        cyc(1'b0, E_LSB, tg);
        cyc(1'b0, E_MID1, tg);
        cyc(1'b0, E_MID2, tg);
        cyc(1'b0, E_MSB, tg);
        cycx(1'b0, E_DONE, co, ops, 1'b1, p, tg);
        cyc(1'b0, E_IDLE, tg);
    endtask

    // Relaunch during MSB, start held through ERR then dropped.
    task automatic err_msb(input logic [15:0] ops, input string tg);
        cyc(1'b1, E_IDLE_L, tg);
        cyc(1'b0, E_LSB, tg);
        cyc(1'b0, E_MID1, tg);
        cyc(1'b0, E_MID2, tg);
        cyc(1'b1, E_MSB, tg);
        cycx(1'b1, E_ERR, 1'b1, ops, 1'b0, 16'h0, tg);
        cyc(1'b0, E_ERR, tg);
        cyc(1'b0, E_IDLE, tg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_err  = 0;
        aclr_n = 1'b0;
        start  = 1'b0;
        a_op   = 8'h00;
        b_op   = 8'h00;

        rst_mid("reset");
        cyc(1'b0, E_IDLE, "idle");

        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, 16'h0, "op_ffxff");
        run_op(8'h12, 8'h34, 16'h03A8, 1'b0, 16'h0, "op_12x34");

        a_op = 8'hA5;
        b_op = 8'h3C;
        cyc(1'b1, E_IDLE_L, "held");
        cyc(1'b1, E_LSB, "held");
        cyc(1'b1, E_MID1, "held");
        cyc(1'b1, E_MID2, "held");
        cyc(1'b1, E_MSB, "held");
        for (int i = 0; i < 4; i++)
            cyc(1'b1, E_DONE, "held");
        cycx(1'b1, E_DONE, 1'b0, 16'h0, 1'b1, 16'h26AC, "held");
        cyc(1'b0, E_DONE, "held_drop");
        cyc(1'b0, E_IDLE, "held_idle");

        cyc(1'b1, E_IDLE_L, "relaunch");
        cyc(1'b0, E_LSB, "relaunch");
        cyc(1'b1, E_MID1, "relaunch");
        cyc(1'b0, E_ERR, "relaunch_err");
        cyc(1'b0, E_IDLE, "relaunch_idle");
        run_op(8'h0F, 8'hF0, 16'h0E10, 1'b0, 16'h0, "after_err");

        cyc(1'b1, E_IDLE_L, "rst_op");
        cyc(1'b0, E_LSB, "rst_op");
        cyc(1'b0, E_MID1, "rst_op");
        cyc(1'b0, E_MID2, "rst_op");
        rst_mid("rst_in_msb");
        cyc(1'b0, E_IDLE, "rst_no_done");
        run_op(8'h80, 8'h02, 16'h0100, 1'b1, 16'd1, "after_rst");

        rst_mid("ops_reset");
        run_op(8'h03, 8'h05, 16'h000F, 1'b1, 16'd1, "ops1");
        run_op(8'h10, 8'h10, 16'h0100, 1'b1, 16'd2, "ops2");
        err_msb(16'd2, "ops_err");
        run_op(8'hFF, 8'h01, 16'h00FF, 1'b1, 16'd3, "ops3");
        run_op(8'h01, 8'hFF, 16'h00FF, 1'b1, 16'd3, "ops_sat4");
        run_op(8'h00, 8'h77, 16'h0000, 1'b1, 16'd3, "ops_sat5");

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencing controller for the 8x8 sequential multiplier.
- Drives the 4x4 multiplier datapath over four nibble-product steps: operand nibble mux select, product shift select, accumulator enable and accumulator clear.
- Owns the 2-bit step counter internally.
- Provides start/done handshake, busy indication, error detection and a state code for display/debug.

Parameters:
- START_EDGE, 1, 1 = operation launched on rising edge of start (start registered internally); 0 = launched on start level high in IDLE.
- OPS_W, 16, width of the optional completed-operation counter.

Ports:
- clk  input  1  clock
- aclr_n  input  1  asynchronous active-low reset
- start  input  1  multiply request
- input_sel  output  2  nibble select: 00=a_lo*b_lo, 01=a_hi*b_lo, 10=a_lo*b_hi, 11=a_hi*b_hi
- shift_sel  output  2  product shift: 00=<<0, 01=<<4, 10=<<8, 11=unused (datapath outputs 0)
- clk_ena  output  1  accumulator register load enable
- sclr_n  output  1  accumulator synchronous clear, active-low
- busy  output  1  high in LSB/MID/MSB
- done_flag  output  1  result valid
- err  output  1  high in ERR
- state_out  output  3  IDLE=000, LSB=001, MID=010, MSB=011, DONE=100, ERR=101
- step_count  output  2  internal step counter value

Behaviour:
- Reset: reset is clk, aclr_n asynchronous active-low. On reset, state=IDLE, step_count=0, start_d=0. Outputs in reset: input_sel=00, shift_sel=00, clk_ena=0, sclr_n=1, busy=0, done_flag=0, err=0, state_out=000.
- Mid-operation reset: aborts immediately to the reset values. No partial done is ever asserted.
- Launch: launch = start & ~start_d when START_EDGE=1; launch = start when START_EDGE=0.
- IDLE:
  - On launch, same cycle (Mealy): sclr_n=0, clk_ena=1, so the accumulator clears on that edge.
  - Next state LSB, step_count <= 0.
- LSB (step_count=0): input_sel=00, shift_sel=00, clk_ena=1. Next state MID, step_count <= 1.
- MID (step_count=1): input_sel=01, shift_sel=01, clk_ena=1. step_count <= 2, stay in MID.
- MID (step_count=2): input_sel=10, shift_sel=01, clk_ena=1. step_count <= 3, next state MSB.
- MSB (step_count=3): input_sel=11, shift_sel=10, clk_ena=1. Next state DONE; step_count wraps to 0.
- DONE:
  - done_flag=1, clk_ena=0; the accumulator holds the 16-bit product.
  - Stays in DONE while start=1.
  - Goes to IDLE when start=0.
  - A start held high through DONE never relaunches; IDLE requires a fresh launch.
- Timing: launch sampled at edge N, with busy high for edges N+1..N+4 and done_flag high from cycle N+5. Exactly 4 accumulate cycles per operation.
- ERR:
  - Entry: a launch condition occurs while in LSB/MID/MSB; for START_EDGE=0, any start=1 in LSB/MID/MSB.
  - Entry takes priority over the normal transition.
  - In ERR: err=1, clk_ena=0, busy=0, done_flag=0.
  - Stays in ERR while start=1; goes to IDLE when start=0.
- Outputs: all outputs except sclr_n and clk_ena in IDLE are pure decodes of registered state/step_count (glitch-free Moore).
- Illegal state codes (110, 111): recover to IDLE on the next edge with IDLE outputs.

Optional Feature:
- Macro: MULT_SEQ_OPS_CNT_EN.
- Defined:
  - Adds output ops_count [OPS_W-1:0], reset to 0 by aclr_n.
  - Increments by 1 on each MSB->DONE transition.
  - Saturates at all-ones; does not wrap.
  - ERR entries do not count.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: aclr_n=0 asynchronously mid-cycle, with no clock edge -> state_out=000, clk_ena=0, sclr_n=1, done_flag=0, step_count=0.
- Normal op (START_EDGE=1): 1-cycle start pulse at edge 0 -> sclr_n=0 during pulse cycle.
  - (input_sel, shift_sel) sequence 00/00, 01/01, 10/01, 11/10 on cycles 1-4.
  - clk_ena=1 on cycles 0-4; done_flag=1 from cycle 5.
  - With the datapath attached, a=8'hFF, b=8'hFF -> accumulator 16'hFE01.
- Held start: start held high 10 cycles -> exactly one operation. State stays DONE (100) until start=0, then IDLE on the next edge.
- Re-launch error: start pulse, then a second rising edge during MID (step_count=1) -> next state ERR (101), err=1, clk_ena=0. With start low -> IDLE, then a new pulse completes normally.
- Reset mid-operation: aclr_n pulsed low in MSB -> immediate IDLE outputs, no done_flag, step_count=0. A subsequent start completes in 5 cycles.
- MULT_SEQ_OPS_CNT_EN defined, OPS_W=2:
  - 5 completed operations -> ops_count 1, 2, 3, 3, 3 (saturates).
  - One ERR episode inserted -> ops_count unchanged.
